// File: rtl/gray_rgb_pkg.sv
// Shared types for the grayscale-to-RGB colouriser: mode encodings, the
// per-frame configuration record and its reset default.
package gray_rgb_pkg;

  // Widest per-channel output supported (OUT_W <= 2 * IN_W <= 32).
  localparam int unsigned CFG_THRESH_W = 32;

  typedef enum logic [1:0] {
    MODE_REPLICATE = 2'd0,
    MODE_THRESH    = 2'd1,
    MODE_HEAT      = 2'd2,
    MODE_RSVD      = 2'd3
  } mode_e;

  // Threshold is held at full width; users slice the low OUT_W bits.
  typedef struct packed {
    mode_e                   mode;
    logic                    invert;
    logic [CFG_THRESH_W-1:0] thresh;
  } cfg_t;

  // Reset-default config: replicate, no invert, threshold at mid-scale.
  function automatic cfg_t cfg_reset(int unsigned out_w);
    cfg_t c;
    c.mode   = MODE_REPLICATE;
    c.invert = 1'b0;
    c.thresh = CFG_THRESH_W'(1) << (out_w - 1);
    return c;
  endfunction

endpackage

// File: rtl/gray_to_rgb_colorizer_if.sv
// Pixel stream bundle: grayscale input beat and RGB output beat with
// valid/ready on each side.
interface gray_to_rgb_colorizer_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [IN_W-1:0]  gray_i;
  logic             last_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OUT_W-1:0] red_o;
  logic [OUT_W-1:0] green_o;
  logic [OUT_W-1:0] blue_o;
  logic             last_o;

  // Source of pixels / sink of colour.
  modport master (
    output in_valid_i, gray_i, last_i, out_ready_i,
    input  in_ready_o, out_valid_o, red_o, green_o, blue_o, last_o
  );

  // The colouriser itself.
  modport slave (
    input  in_valid_i, gray_i, last_i, out_ready_i,
    output in_ready_o, out_valid_o, red_o, green_o, blue_o, last_o
  );
endinterface

// File: rtl/gray_rgb_heatmap.sv
// Combinational heatmap: top two bits pick a segment of a blue-green-yellow-red
// ramp, the remaining bits (MSB-extended back to OUT_W) give the position in it.
module gray_rgb_heatmap #(
  parameter int unsigned OUT_W = 8
) (
  input  logic [OUT_W-1:0] s_i,
  output logic [OUT_W-1:0] red_o,
  output logic [OUT_W-1:0] green_o,
  output logic [OUT_W-1:0] blue_o
);

  logic [1:0]       seg;
  logic [OUT_W-1:0] frac;
  logic [OUT_W-1:0] full;

  assign seg  = s_i[OUT_W-1 -: 2];
  assign frac = {s_i[OUT_W-3:0], s_i[OUT_W-3 -: 2]};
  assign full = {OUT_W{1'b1}};

  // Segment decode to channel values.
  always_comb begin
    red_o   = '0;
    green_o = '0;
    blue_o  = '0;
    case (seg)
      2'd0: begin
        green_o = frac;
        blue_o  = full;
      end
      2'd1: begin
        green_o = full;
        blue_o  = ~frac;
      end
      2'd2: begin
        red_o   = frac;
        green_o = full;
      end
      default: begin
        red_o   = full;
        green_o = ~frac;
      end
    endcase
  end

endmodule

// File: rtl/gray_to_rgb_colorizer.sv
// Grayscale-to-RGB colouriser: 2-stage valid/ready pipeline with frame-stable
// configuration (replicate / threshold / heatmap) and per-frame pixel count.
module gray_to_rgb_colorizer
  import gray_rgb_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  gray_to_rgb_colorizer_if.slave   bus,
  input  logic [1:0]               cfg_mode_i,
  input  logic                     cfg_invert_i,
  input  logic [OUT_W-1:0]         cfg_thresh_i,
  output logic                     frame_done_o,
  output logic [CNT_W-1:0]         frame_pixels_o
);

  localparam cfg_t CfgRst = cfg_reset(OUT_W);

  logic en, accept, emit;

  // Frame / config state
  logic frame_open_q, frame_open_d;
  cfg_t act_q, act_d;
  cfg_t cfg_in, cfg_eff;

  // Stage 1
  logic             valid1_q, valid1_d;
  logic [OUT_W-1:0] s1_q, s1_d;
  mode_e            mode1_q, mode1_d;
  logic [OUT_W-1:0] thresh1_q, thresh1_d;
  logic             last1_q, last1_d;

  // Stage 2
  logic             valid2_q, valid2_d;
  logic [OUT_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic             last2_q, last2_d;

  // Statistics
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] frame_pix_q, frame_pix_d;

  logic [OUT_W-1:0] scaled;
  logic [OUT_W-1:0] heat_r, heat_g, heat_b;
  logic [OUT_W-1:0] map_r, map_g, map_b;
  logic             unused_thresh;

  // Whole pipe advances together; a bubble in stage 2 keeps it moving.
  assign en             = bus.out_ready_i | ~valid2_q;
  assign bus.in_ready_o = en;
  assign accept         = bus.in_valid_i & en;
  assign emit           = valid2_q & bus.out_ready_i;

  assign bus.out_valid_o = valid2_q;
  assign bus.red_o       = red_q;
  assign bus.green_o     = green_q;
  assign bus.blue_o      = blue_q;
  assign bus.last_o      = last2_q;
  assign frame_done_o    = emit & last2_q;
  assign frame_pixels_o  = frame_pix_q;

  // MSB bit-replication widens IN_W to OUT_W.
  if (OUT_W == IN_W) begin : g_same_w
    assign scaled = bus.gray_i;
  end else begin : g_ext_w
    assign scaled = {bus.gray_i, bus.gray_i[IN_W-1 -: OUT_W-IN_W]};
  end

  // Live config inputs apply until a frame opens, then the latched copy does.
  always_comb begin
    cfg_in                = '0;
    cfg_in.mode           = mode_e'(cfg_mode_i);
    cfg_in.invert         = cfg_invert_i;
    cfg_in.thresh[OUT_W-1:0] = cfg_thresh_i;
    cfg_eff               = frame_open_q ? act_q : cfg_in;
  end

  // Only the low OUT_W threshold bits reach the compare.
  assign unused_thresh = ^cfg_eff.thresh;

  // Frame tracking, config latch and pixel counter.
  always_comb begin
    frame_open_d = frame_open_q;
    act_d        = act_q;
    cnt_d        = cnt_q;
    frame_pix_d  = frame_pix_q;
    cnt_inc      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    if (accept) begin
      if (!frame_open_q) begin
        act_d = cfg_in;
      end
      frame_open_d = ~bus.last_i;
      if (bus.last_i) begin
        frame_pix_d = cnt_inc;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Stage 1 next state: scaled/inverted intensity plus the config it needs.
  always_comb begin
    valid1_d  = valid1_q;
    s1_d      = s1_q;
    mode1_d   = mode1_q;
    thresh1_d = thresh1_q;
    last1_d   = last1_q;
    if (en) begin
      valid1_d = accept;
    end
    if (accept) begin
      s1_d      = cfg_eff.invert ? ~scaled : scaled;
      mode1_d   = cfg_eff.mode;
      thresh1_d = cfg_eff.thresh[OUT_W-1:0];
      last1_d   = bus.last_i;
    end
  end

  gray_rgb_heatmap #(
    .OUT_W (OUT_W)
  ) u_heatmap (
    .s_i     (s1_q),
    .red_o   (heat_r),
    .green_o (heat_g),
    .blue_o  (heat_b)
  );

  // Colour mapping by mode; reserved mode falls through to replicate.
  always_comb begin
    map_r = s1_q;
    map_g = s1_q;
    map_b = s1_q;
    case (mode1_q)
      MODE_THRESH: begin
        map_r = (s1_q >= thresh1_q) ? {OUT_W{1'b1}} : '0;
        map_g = map_r;
        map_b = map_r;
      end
      MODE_HEAT: begin
        map_r = heat_r;
        map_g = heat_g;
        map_b = heat_b;
      end
      default: ;
    endcase
  end

  // Stage 2 next state: registered RGB held while stalled.
  always_comb begin
    valid2_d = valid2_q;
    red_d    = red_q;
    green_d  = green_q;
    blue_d   = blue_q;
    last2_d  = last2_q;
    if (en) begin
      valid2_d = valid1_q;
      if (valid1_q) begin
        red_d   = map_r;
        green_d = map_g;
        blue_d  = map_b;
        last2_d = last1_q;
      end
    end
  end

  // State registers; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_open_q <= 1'b0;
      act_q        <= CfgRst;
      cnt_q        <= '0;
      frame_pix_q  <= '0;
      valid1_q     <= 1'b0;
      s1_q         <= '0;
      mode1_q      <= MODE_REPLICATE;
      thresh1_q    <= CfgRst.thresh[OUT_W-1:0];
      last1_q      <= 1'b0;
      valid2_q     <= 1'b0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      last2_q      <= 1'b0;
    end else begin
      frame_open_q <= frame_open_d;
      act_q        <= act_d;
      cnt_q        <= cnt_d;
      frame_pix_q  <= frame_pix_d;
      valid1_q     <= valid1_d;
      s1_q         <= s1_d;
      mode1_q      <= mode1_d;
      thresh1_q    <= thresh1_d;
      last1_q      <= last1_d;
      valid2_q     <= valid2_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      last2_q      <= last2_d;
    end
  end

endmodule

// File: tb/tb_gray_to_rgb_colorizer.sv
// Bench for gray_to_rgb_colorizer: scoreboard of expected RGB pushed on each
// accepted pixel and popped on each emitted beat.
module tb_gray_to_rgb_colorizer;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 10;
  localparam int unsigned CNT_W = 20;
  localparam int          MAXV  = (1 << OUT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       cfg_mode;
  logic             cfg_invert;
  logic [OUT_W-1:0] cfg_thresh;
  logic             frame_done;
  logic [CNT_W-1:0] frame_pixels;
  bit               stream_done;

  gray_to_rgb_colorizer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  gray_to_rgb_colorizer #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .cfg_mode_i     (cfg_mode),
    .cfg_invert_i   (cfg_invert),
    .cfg_thresh_i   (cfg_thresh),
    .frame_done_o   (frame_done),
    .frame_pixels_o (frame_pixels)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int g;
    int b;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state for frame-stable config and pixel counting
  bit m_open;
  int m_mode;
  bit m_inv;
  int m_thresh;
  int m_cnt;
  int m_frame_pix;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int g, input int mode, input bit inv, input int thr,
                                 input bit last);
    exp_t e;
    int   s, seg, f, v;
    s = ((g << (OUT_W - IN_W)) | (g >> (2 * IN_W - OUT_W))) & MAXV;
    if (inv) s = s ^ MAXV;
    e.last = last;
    case (mode)
      1: begin
        v = (s >= thr) ? MAXV : 0;
        e.r = v; e.g = v; e.b = v;
      end
      2: begin
        seg = s >> (OUT_W - 2);
        f   = ((s << 2) & MAXV) | ((s >> (OUT_W - 4)) & 3);
        case (seg)
          0:       begin e.r = 0;    e.g = f;           e.b = MAXV;     end
          1:       begin e.r = 0;    e.g = MAXV;        e.b = f ^ MAXV; end
          2:       begin e.r = f;    e.g = MAXV;        e.b = 0;        end
          default: begin e.r = MAXV; e.g = f ^ MAXV;    e.b = 0;        end
        endcase
      end
      default: begin
        e.r = s; e.g = s; e.b = s;
      end
    endcase
    return e;
  endfunction

  // Monitor: compare emitted beats, then record the beat being accepted.
  always @(negedge clk) begin
    bit   acc;
    bit   emt;
    int   nxt;
    exp_t e;
    if (!rst_n) begin
      m_open      = 1'b0;
      m_mode      = 0;
      m_inv       = 1'b0;
      m_thresh    = 1 << (OUT_W - 1);
      m_cnt       = 0;
      m_frame_pix = 0;
      sb.delete();
    end else begin
      acc = bus.in_valid_i && bus.in_ready_o;
      emt = bus.out_valid_o && bus.out_ready_i;
      check("frame_pixels", frame_pixels, m_frame_pix);
      if (emt) begin
        if (sb.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("red", bus.red_o, e.r);
          check("green", bus.green_o, e.g);
          check("blue", bus.blue_o, e.b);
          check("last_o", bus.last_o, e.last);
          check("frame_done", frame_done, e.last);
        end
      end else begin
        check("frame_done_idle", frame_done, 0);
      end
      if (acc) begin
        if (!m_open) begin
          m_mode   = cfg_mode;
          m_inv    = cfg_invert;
          m_thresh = cfg_thresh;
        end
        sb.push_back(model(bus.gray_i, m_mode, m_inv, m_thresh, bus.last_i));
        nxt = (m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1;
        if (bus.last_i) begin
          m_frame_pix = nxt;
          m_cnt       = 0;
        end else begin
          m_cnt = nxt;
        end
        m_open = !bus.last_i;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int g, input bit last);
    bit acc;
    int guard;
    guard = 0;
    bus.in_valid_i = 1'b1;
    bus.gray_i     = g[IN_W-1:0];
    bus.last_i     = last;
    do begin
      @(negedge clk);
      acc = bus.in_ready_o;
      step();
      guard++;
    end while (!acc && guard < 100);
    if (!acc) check("send_timeout", 0, 1);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || bus.out_valid_o) && guard < 200) begin
      step();
      guard++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.gray_i      = '0;
    bus.last_i      = 1'b0;
    bus.out_ready_i = 1'b1;
    cfg_mode        = 2'd0;
    cfg_invert      = 1'b0;
    cfg_thresh      = 10'h200;
    rst_n           = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_red", bus.red_o, 0);
    check("rst_green", bus.green_o, 0);
    check("rst_blue", bus.blue_o, 0);
    check("rst_last", bus.last_o, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_pixels", frame_pixels, 0);
    check("rst_in_ready", bus.in_ready_o, 1);
    rst_n = 1'b1;
    step();

    // Replicate, 8->10 bit widening, two-cycle latency, 1-pixel frame
    send(8'hA5, 1'b1);
    check("lat_not_yet", bus.out_valid_o, 0);
    step();
    check("lat_valid", bus.out_valid_o, 1);
    check("lat_red", bus.red_o, 10'h296);
    check("lat_blue", bus.blue_o, 10'h296);
    check("lat_frame_done", frame_done, 1);
    drain();
    check("one_pix_frame", frame_pixels, 1);

    // Heatmap segment boundaries
    cfg_mode = 2'd2;
    send(8'h00, 1'b0);
    send(8'h80, 1'b0);
    send(8'hFF, 1'b1);
    drain();

    // Threshold either side of mid-scale, then inverted
    cfg_mode = 2'd1;
    send(8'h7F, 1'b0);
    send(8'h80, 1'b1);
    cfg_invert = 1'b1;
    send(8'h10, 1'b1);
    send(8'hF0, 1'b1);
    cfg_invert = 1'b0;
    drain();

    // Mode change mid-frame takes effect only on the next frame
    cfg_mode = 2'd0;
    send(8'h33, 1'b0);
    cfg_mode = 2'd1;
    send(8'h44, 1'b0);
    send(8'h90, 1'b1);
    send(8'h90, 1'b1);
    send(8'h20, 1'b1);
    drain();

    // Downstream stall during a 6-pixel stream
    cfg_mode = 2'd0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(8'h20 + i * 17, i == 5);
      end
      begin
        step();
        step();
        bus.out_ready_i = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("stall_in_ready", bus.in_ready_o, 0);
        check("stall_out_valid", bus.out_valid_o, 1);
        step();
        step();
        bus.out_ready_i = 1'b1;
      end
    join
    drain();

    // 100-pixel heatmap frame with random downstream backpressure
    cfg_mode    = 2'd2;
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) send($urandom_range(0, 255), i == 99);
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          bus.out_ready_i = ($urandom_range(0, 3) != 0);
          step();
        end
        bus.out_ready_i = 1'b1;
      end
    join
    drain();
    check("frame_100", frame_pixels, 100);

    // Reset mid-frame with both stages full
    cfg_mode        = 2'd0;
    bus.out_ready_i = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    check("pre_rst_full", bus.out_valid_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid_o, 0);
    check("mid_rst_red", bus.red_o, 0);
    check("mid_rst_last", bus.last_o, 0);
    check("mid_rst_frame_pixels", frame_pixels, 0);
    check("mid_rst_in_ready", bus.in_ready_o, 1);
    step();
    step();
    rst_n           = 1'b1;
    bus.out_ready_i = 1'b1;
    cfg_mode        = 2'd1;
    send(8'hF0, 1'b0);
    send(8'h01, 1'b1);
    drain();
    check("post_rst_frame", frame_pixels, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gray_to_rgb_colorizer.md
# gray_to_rgb_colorizer

Parametrised, handshaked successor to the fixed 8-bit grayscale-to-RGB expander in the edge-detection output path. It takes one grayscale pixel per beat from the Sobel magnitude stream and produces RGB via one of three frame-stable colour modes: replicate, threshold, or heatmap. It has a 2-stage pipeline with valid/ready backpressure, and keeps per-frame pixel statistics for the display/VGA side.

## Interface
- IN_W, 8: grayscale input width; 4 ≤ IN_W ≤ 16.
- OUT_W, 8: per-channel output width; IN_W ≤ OUT_W ≤ 2·IN_W.
- CNT_W, 20: pixel counter width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  input pixel valid.
- in_ready_o  out  1  block can accept a pixel.
- gray_i  in  IN_W  grayscale pixel.
- last_i  in  1  last pixel of frame (replaces the old done flag).
- cfg_mode_i  in  2  0 = replicate, 1 = threshold, 2 = heatmap, 3 = reserved (behaves as 0).
- cfg_invert_i  in  1  invert intensity before mapping.
- cfg_thresh_i  in  OUT_W  threshold for mode 1.
- out_valid_o  out  1  RGB valid.
- out_ready_i  in  1  downstream accepts.
- red_o / green_o / blue_o  out  OUT_W each  colour channels.
- last_o  out  1  last_i delayed with its pixel.
- frame_done_o  out  1  one-cycle pulse when a pixel with last_o = 1 is accepted downstream.
- frame_pixels_o  out  CNT_W  pixel count of the most recently completed frame.

## Operation
- Accept = in_valid_i & in_ready_o. Emit = out_valid_o & out_ready_i.
- Scaling: s = {gray_i, gray_i[IN_W-1 -: OUT_W-IN_W]} (MSB bit-replication); s = gray_i when OUT_W = IN_W. With invert set, s = ~s.
- Config is frame-stable.
  - frame_open register: set on an accept with last_i = 0; cleared on an accept with last_i = 1.
  - While frame_open = 0, the effective config is the cfg inputs directly, and the active config register loads them on every accept.
  - While frame_open = 1, the effective config is the active register. cfg input changes are ignored until the next frame.
- Mode 0: R = G = B = s.
- Mode 1: all channels all-ones if s ≥ cfg_thresh_i, else zero.
- Mode 2: seg = s[OUT_W-1:OUT_W-2], f = {s[OUT_W-3:0], s[OUT_W-3 -: 2]}, M = all-ones.
  - seg0 → (0, f, M)
  - seg1 → (0, M, ~f)
  - seg2 → (f, M, 0)
  - seg3 → (M, ~f, 0)
- Counter:
  - Increments on every accept and saturates at 2^CNT_W − 1.
  - On an accept with last_i = 1, frame_pixels_o ← counter + 1 (saturating) and the counter clears to 0.

## Timing
- Stage 1 registers s, effective config and last. Stage 2 registers RGB and last_o.
- Latency is 2 cycles from accept to out_valid_o when unstalled; throughput is 1 pixel per cycle.
- Stall: the pipeline enable is en = out_ready_i | ~out_valid_o, and in_ready_o = en.
  - This is a combinational ready-to-ready path; it is an accepted design choice.
  - Both stages hold their contents while en = 0.
  - A bubble in stage 2 does not block acceptance.
- Under stall, out_valid_o and the data outputs stay stable until emitted.
- frame_done_o asserts in the cycle of the last_o emit and is a one-cycle pulse only.
- Reset (asynchronous, immediate, may occur mid-frame):
  - All valid bits, RGB, last_o, frame_done_o, counter and frame_pixels_o are 0.
  - frame_open = 0; active config = mode 0, invert 0, thresh = 2^(OUT_W-1).
  - In-flight pixels are dropped.
  - in_ready_o = 1 after reset.

## Structure
- Shared package gray_rgb_pkg holds:
  - mode encodings: MODE_REPLICATE, MODE_THRESH, MODE_HEAT
  - the cfg record typedef {mode, invert, thresh}
  - the reset-default config constant
- One sub-module, gray_rgb_heatmap: purely combinational s → RGB mapping, parametrised by OUT_W, instantiated in stage 2.

## Test plan
- Mode 0, IN_W = 8, OUT_W = 10, gray 0xA5, out_ready_i held high → R = G = B = 0x296 exactly 2 cycles after accept.
- Mode 2, OUT_W = 8, inputs 0x00 / 0x80 / 0xFF → (0, 0, 255) / (0, 255, 0) / (255, 0, 0). Mode 1 with thresh 0x80: 0x7F → all 0, 0x80 → all 0xFF.
- cfg_mode_i changed from 0 to 1 mid-frame → the rest of the frame stays replicate; the first pixel after last is thresholded.
- out_ready_i low for 5 cycles during a 6-pixel stream → outputs held stable, in_ready_o low while the pipe is full, no loss or duplication, order preserved.
- 100-pixel frame with last on the final pixel → frame_pixels_o = 100 and a single frame_done_o pulse on the last emit. A 1-pixel frame → frame_pixels_o = 1.
- rst_n asserted mid-frame with both stages full → outputs go to 0 immediately. The next frame counts from 0 and uses the current cfg inputs.
